// File: rtl/usb_rx_buffer_if.sv
// Receive-buffer handshake bundle: host-side push port, FT245-style read port,
// and status/flag outputs.
interface usb_rx_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  full_o;
    logic                  afull_o;
    logic                  rd_i;
    logic                  rxf_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [ADDR_WIDTH:0]   level_o;
    logic                  ovf_o;
    logic                  unf_o;
    logic                  clr_flags_i;

    modport master (
        output wr_i, wdata_i, rd_i, clr_flags_i,
        input  full_o, afull_o, rxf_o, data_o, level_o, ovf_o, unf_o
    );

    modport slave (
        input  wr_i, wdata_i, rd_i, clr_flags_i,
        output full_o, afull_o, rxf_o, data_o, level_o, ovf_o, unf_o
    );
endinterface

// File: rtl/usb_rx_buffer.sv
// Circular receive buffer between the USB host-data source and the command
// decoder, drained through an FT245-style rxf/rd handshake with read turnaround.
module usb_rx_buffer #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_LEVEL   = 12,
    parameter int RD_TURNAROUND = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    usb_rx_buffer_if.slave  bus
);
    localparam int unsigned         DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [3:0]          TURN_C  = 4'(RD_TURNAROUND);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count;
    logic [3:0]            tcnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  ovf_q;
    logic                  unf_q;

    logic full;
    logic rxf;
    logic wr_acc;
    logic rd_acc;

    // Acceptance is judged on pre-edge count, so a write at full is dropped
    // even when a read frees a slot on the same edge.
    always_comb begin
        full   = (count == DEPTH_C);
        rxf    = (count != '0) && (tcnt == '0);
        wr_acc = bus.wr_i && !full;
        rd_acc = bus.rd_i && rxf;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_acc) begin
            mem[wptr] <= bus.wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            tcnt   <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end

            if (rd_acc) begin
                data_q <= mem[rptr];
                rptr   <= rptr + 1'b1;
                tcnt   <= TURN_C;
            end else if (tcnt != '0) begin
                tcnt <= tcnt - 1'b1;
            end

            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // Set events take priority over a simultaneous clear.
            if (bus.wr_i && !wr_acc) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_flags_i) begin
                ovf_q <= 1'b0;
            end

            if (bus.rd_i && !rxf) begin
                unf_q <= 1'b1;
            end else if (bus.clr_flags_i) begin
                unf_q <= 1'b0;
            end
        end
    end

    assign bus.full_o  = full;
    assign bus.afull_o = (count >= AFULL_C);
    assign bus.rxf_o   = rxf;
    assign bus.data_o  = data_q;
    assign bus.level_o = count;
    assign bus.ovf_o   = ovf_q;
    assign bus.unf_o   = unf_q;
endmodule

// File: tb/tb_usb_rx_buffer.sv
// Self-checking bench: two buffers (turnaround 1 and 0) driven with identical
// directed and random stimulus, compared every cycle against a queue model.
module tb_usb_rx_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [7:0] wdata;
    logic       rd;
    logic       clr;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    usb_rx_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus0 ();
    usb_rx_buffer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus1 ();

    assign bus0.wr_i        = wr;
    assign bus0.wdata_i     = wdata;
    assign bus0.rd_i        = rd;
    assign bus0.clr_flags_i = clr;
    assign bus1.wr_i        = wr;
    assign bus1.wdata_i     = wdata;
    assign bus1.rd_i        = rd;
    assign bus1.clr_flags_i = clr;

    usb_rx_buffer #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_LEVEL(12), .RD_TURNAROUND(1)
    ) dut_t1 (
        .clk_i(clk), .rst_i(rst), .bus(bus0.slave)
    );

    usb_rx_buffer #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_LEVEL(12), .RD_TURNAROUND(0)
    ) dut_t0 (
        .clk_i(clk), .rst_i(rst), .bus(bus1.slave)
    );

    logic [7:0] o_data  [2];
    logic [4:0] o_level [2];
    logic       o_full  [2];
    logic       o_afull [2];
    logic       o_rxf   [2];
    logic       o_ovf   [2];
    logic       o_unf   [2];

    assign o_data[0]  = bus0.data_o;   assign o_data[1]  = bus1.data_o;
    assign o_level[0] = bus0.level_o;  assign o_level[1] = bus1.level_o;
    assign o_full[0]  = bus0.full_o;   assign o_full[1]  = bus1.full_o;
    assign o_afull[0] = bus0.afull_o;  assign o_afull[1] = bus1.afull_o;
    assign o_rxf[0]   = bus0.rxf_o;    assign o_rxf[1]   = bus1.rxf_o;
    assign o_ovf[0]   = bus0.ovf_o;    assign o_ovf[1]   = bus1.ovf_o;
    assign o_unf[0]   = bus0.unf_o;    assign o_unf[1]   = bus1.unf_o;

    // Reference model: a plain FIFO queue plus a "reads blocked for N cycles" timer.
    int mq [2][$];
    int m_data [2];
    int m_busy [2];
    bit m_ovf  [2];
    bit m_unf  [2];
    int turn   [2];

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit m_rxf(input int k);
        return (mq[k].size() != 0) && (m_busy[k] == 0);
    endfunction

    task automatic model_edge(input bit w, input int d, input bit r, input bit c, input bit rs);
        for (int k = 0; k < 2; k++) begin
            if (rs) begin
                mq[k].delete();
                m_data[k] = 0;
                m_busy[k] = 0;
                m_ovf[k]  = 1'b0;
                m_unf[k]  = 1'b0;
            end else begin
                bit rxf_pre = m_rxf(k);
                bit racc    = r && rxf_pre;
                bit wacc    = w && (mq[k].size() < 16);
                if (racc) m_data[k] = mq[k].pop_front();
                if (wacc) mq[k].push_back(d & 8'hFF);
                if (w && !wacc) m_ovf[k] = 1'b1;
                else if (c)     m_ovf[k] = 1'b0;
                if (r && !rxf_pre) m_unf[k] = 1'b1;
                else if (c)        m_unf[k] = 1'b0;
                if (racc)              m_busy[k] = turn[k];
                else if (m_busy[k] > 0) m_busy[k]--;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            string p = (k == 0) ? "t1" : "t0";
            check({p, ".level"}, o_level[k], mq[k].size());
            check({p, ".full"},  o_full[k],  mq[k].size() == 16);
            check({p, ".afull"}, o_afull[k], mq[k].size() >= 12);
            check({p, ".rxf"},   o_rxf[k],   m_rxf(k));
            check({p, ".data"},  o_data[k],  m_data[k]);
            check({p, ".ovf"},   o_ovf[k],   m_ovf[k]);
            check({p, ".unf"},   o_unf[k],   m_unf[k]);
            check({p, ".level_max"}, o_level[k] <= 5'd16, 1);
        end
    endtask

    task automatic step(input bit w, input int d, input bit r, input bit c, input bit rs);
        wr    = w;
        wdata = d[7:0];
        rd    = r;
        clr   = c;
        rst   = rs;
        @(posedge clk);
        model_edge(w, d, r, c, rs);
        #1;
        compare_all();
    endtask

    initial begin
        turn[0] = 1;
        turn[1] = 0;
        rst = 1'b1; wr = 1'b0; wdata = '0; rd = 1'b0; clr = 1'b0;

        // Reset values, then a reset mid-stream with wr held high.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            check("rst.level", o_level[k], 0);
            check("rst.rxf",   o_rxf[k],   0);
            check("rst.data",  o_data[k],  0);
        end
        for (int i = 0; i < 3; i++) step(1, 8'h50 + i, 0, 0, 0);
        step(1, 8'h60, 0, 0, 1);
        step(1, 8'h61, 0, 0, 1);
        for (int k = 0; k < 2; k++) check("midrst.level", o_level[k], 0);
        step(1, 8'h62, 0, 0, 0);
        for (int k = 0; k < 2; k++) check("post_rst.level", o_level[k], 1);

        // Fill to overflow with 0x00..0x10.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i <= 16; i++) step(1, i, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            check("fill.level", o_level[k], 16);
            check("fill.full",  o_full[k],  1);
            check("fill.ovf",   o_ovf[k],   1);
        end

        // Drain with rd held high; keep going past empty to provoke underflow.
        for (int i = 0; i < 36; i++) step(0, 0, 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            check("drain.last", o_data[k],  8'h0F);
            check("drain.unf",  o_unf[k],   1);
            check("drain.rxf",  o_rxf[k],   0);
        end

        // Simultaneous push/pop at full, then flag clear.
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) step(1, 8'h80 + i, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 8'hAA, 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            check("fullrw.level", o_level[k], 15);
            check("fullrw.ovf",   o_ovf[k],   1);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int k = 0; k < 2; k++) check("clr.ovf", o_ovf[k], 0);

        // Set beats clear on the same edge.
        step(1, 8'h90, 0, 0, 0);
        step(1, 8'h91, 0, 1, 0);
        for (int k = 0; k < 2; k++) check("prio.ovf", o_ovf[k], 1);
        for (int i = 0; i < 34; i++) step(0, 0, 1, 0, 0);

        // Back-to-back interleave across several pointer wraps.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 40; i++) step(1, 8'hC0 + i, 1, 0, 0);
        for (int i = 0; i < 24; i++) step(0, 0, 1, 0, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit w  = ($urandom_range(0, 99) < 60);
            bit r  = ($urandom_range(0, 99) < 50);
            bit c  = ($urandom_range(0, 15) == 0);
            bit rs = ($urandom_range(0, 99) == 0);
            step(w, $urandom_range(0, 255), r, c, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/usb_rx_buffer.md
# usb_rx_buffer

Synthesizable, parametrised successor to the FT2232H receive-side model. Host-side bytes are pushed into an on-chip circular buffer. The buffer is drained through an FT245-style read handshake: `rxf_o` signals that data is available, and a `rd_i` strobe pops one word. It adds what the behavioural model lacks: configurable width and depth, read turnaround, fill-level and almost-full reporting, and sticky overflow/underflow flags. It sits between the USB host-data source and the FPGA command decoder.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: word width.
- `ADDR_WIDTH`, default 4: buffer depth is `DEPTH = 2**ADDR_WIDTH` (16).
- `AFULL_LEVEL`, default 12: `afull_o` threshold, valid range 1..DEPTH.
- `RD_TURNAROUND`, default 1: cycles `rxf_o` is forced low after each accepted read, valid range 0..15.

Ports:
- `clk_i`  in  1  sole clock; everything is rising-edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `wr_i`  in  1  push request.
- `wdata_i`  in  DATA_WIDTH  push data.
- `full_o`  out  1  count == DEPTH.
- `afull_o`  out  1  count >= AFULL_LEVEL.
- `rd_i`  in  1  read strobe.
- `rxf_o`  out  1  data available, read permitted.
- `data_o`  out  DATA_WIDTH  last popped word, registered.
- `level_o`  out  ADDR_WIDTH+1  current count, 0..DEPTH.
- `ovf_o`  out  1  sticky: a write was dropped.
- `unf_o`  out  1  sticky: a read was issued while `rxf_o` was 0.
- `clr_flags_i`  in  1  clears `ovf_o` and `unf_o`.

Reset and clock are fixed: one clock `clk_i`; reset `rst_i` is synchronous and active-high.

## Operation
- **State:** `wptr`, `rptr` (ADDR_WIDTH bits each, natural modulo-DEPTH wrap), `count` (ADDR_WIDTH+1 bits), turnaround counter `tcnt`, `data_o` register, and the two flag registers.
- **Reset:** on an edge with `rst_i`=1, all state goes to 0. Resulting outputs: `data_o`=0, `rxf_o`=0, `full_o`=0, `afull_o`=0, `level_o`=0, `ovf_o`=0, `unf_o`=0. Reset mid-transfer discards buffer contents; memory contents need not be cleared.
- **Write acceptance:** `wr_i`=1 and `count` < DEPTH, evaluated on pre-edge `count`. On accept, `wdata_i` is stored at `wptr` and `wptr` increments. If `wr_i`=1 with `count`==DEPTH, the word is dropped and `ovf_o` is set. This holds even when a read is accepted in the same cycle.
- **Read acceptance:** `rd_i`=1 and `rxf_o`=1. On accept:
  - `data_o` loads `mem[rptr]` and `rptr` increments;
  - `tcnt` loads `RD_TURNAROUND`.
- **Invalid read:** `rd_i`=1 with `rxf_o`=0 sets `unf_o`. `data_o`, pointers and `count` are unchanged.
- **Turnaround:** `tcnt` decrements while nonzero.
- **Output decode:**
  - `rxf_o` = (`count` != 0) && (`tcnt` == 0), decoded from registers only.
  - `full_o` = (`count` == DEPTH).
  - `afull_o` = (`count` >= AFULL_LEVEL).
  - `level_o` = `count`.
- **Count update:** accepted write only: +1. Accepted read only: −1. Both: unchanged. Neither: unchanged.
- **Flag clear:** `clr_flags_i`=1 clears both flags. If a set event occurs in the same cycle, set wins.

## Timing
- **Write to visibility:** a write accepted at edge N makes `level_o`, `full_o` and `afull_o` reflect it from edge N onward. When the buffer was empty, `rxf_o` rises after edge N (if `tcnt`==0). There is no same-cycle fall-through from `wdata_i` to `data_o`.
- **Read latency:** a read accepted at edge M puts the popped word on `data_o` after edge M (one-cycle latency from `rd_i` high). `data_o` then holds until the next accepted read.
- **Turnaround window:** after an accepted read at edge M, `rxf_o` is 0 for `RD_TURNAROUND` cycles.
  - `RD_TURNAROUND`=1: the next read can be accepted at edge M+2 at the earliest.
  - `RD_TURNAROUND`=0: `rd_i` held high drains one word per cycle.
- **Read at full:** with `count`==DEPTH and both `wr_i` and `rd_i` high, the read is accepted, the write is dropped, `ovf_o`=1, and `count` becomes DEPTH−1.
- **Write/read at one word:** with `count`==1, both `wr_i` and `rd_i` high, and `rxf_o`=1, both are accepted and `count` stays 1. `rxf_o` then drops only because of turnaround.
- **Pointer wrap:** pointers wrap from DEPTH−1 to 0 with no gap or bubble.

## Test plan
- **Reset values:** assert `rst_i` for 2 cycles mid-stream, with `wr_i`=1 held high during those cycles.
  - During reset: no write is accepted.
  - After release: all outputs are 0, then the next accepted write gives `level_o`=1.
- **Fill to overflow:** push 0x00..0x10 (17 writes) on consecutive cycles, default parameters.
  - `afull_o` rises after write 12 and `full_o` after write 16.
  - Word 0x10 is dropped, `ovf_o`=1, `level_o`=16.
- **Drain with turnaround:** hold `rd_i` high on the full buffer, `RD_TURNAROUND`=1.
  - `data_o` sequence is 0x00..0x0F, one word per 2 cycles, and nothing else.
  - `rxf_o` is 0 after the last word, then `unf_o` sets on the next `rd_i`.
- **Simultaneous push/pop at full:** with `count`==16, `wr_i` and `rd_i` both high for one cycle (wdata=0xAA).
  - `level_o`=15, `ovf_o`=1, 0xAA is not stored.
  - `clr_flags_i` on a later cycle clears `ovf_o`.
- **Wrap and back-to-back:** `RD_TURNAROUND`=0, interleave 40 writes and reads of an incrementing pattern.
  - Output order matches input across 2+ pointer wraps.
  - Continuous `rd_i` gives one word per cycle, and `level_o` never exceeds 16.
- **Flag clear priority:** assert `clr_flags_i` in the same cycle as a dropped write. `ovf_o` remains 1.
